// File: rtl/button_ctrl_n_pkg.sv
// button_ctrl_n_pkg: register map, debounce FSM encoding and shared helpers.
package button_ctrl_n_pkg;
    localparam logic [7:0] OFF_STATUS   = 8'h00;
    localparam logic [7:0] OFF_RAW      = 8'h04;
    localparam logic [7:0] OFF_PRESS    = 8'h08;
    localparam logic [7:0] OFF_RELEASE  = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h10;
    localparam logic [7:0] OFF_DEBOUNCE = 8'h14;

    localparam int IRQ_REL_BIT = 31;

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // Last counter value of a debounce window; a window of 0 behaves as 1.
    function automatic logic [15:0] deb_last(input logic [15:0] deb);
        return (deb == 16'd0) ? 16'd0 : deb - 16'd1;
    endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- synchronizer, debounce FSM, counter and edge pulses.
module btn_debounce_ch
    import button_ctrl_n_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_n_i,
    input  logic [15:0] deb_i,
    output logic        raw_o,
    output logic        stable_o,
    output logic        press_o,
    output logic        release_o
);
    logic        meta_q, sync_q, stable_q, stable_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, last;
    logic        diff, toggle;

    always_comb begin
        last     = deb_last(deb_i);
        diff     = sync_q ^ stable_q;
        // counter holds (differing cycles - 1), so its successor is compared; a 1-cycle window toggles straight from STABLE
        toggle   = diff && ((state_q == ST_STABLE) ? (last == 16'd0) : ({1'b0, cnt_q} + 17'd1 >= {1'b0, last}));
        state_d  = (diff && !toggle) ? ST_COUNTING : ST_STABLE;
        cnt_d    = (state_q == ST_COUNTING && diff && !toggle) ? cnt_q + 16'd1 : 16'd0;
        stable_d = stable_q ^ toggle;
    end

    // The pin is inverted on entry so that reset (all zero) means released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            state_q  <= ST_STABLE;
            cnt_q    <= 16'd0;
            stable_q <= 1'b0;
        end else begin
            meta_q   <= ~btn_n_i;
            sync_q   <= meta_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign raw_o     = sync_q;
    assign stable_o  = stable_q;
    assign press_o   = toggle & ~stable_q;
    assign release_o = toggle & stable_q;
endmodule

// File: rtl/button_ctrl_n.sv
// button_ctrl_n: debounced multi-button controller with sticky press/release flags, register bus and IRQ.
module button_ctrl_n
    import button_ctrl_n_pkg::*;
#(
    parameter int          NUM_BTN   = 10,
    parameter logic [15:0] DEB_RESET = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic               ren,
    input  logic               wen,
    input  logic [7:0]         address,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               irq
);
    logic [NUM_BTN-1:0] raw, stable, press_p, release_p;
    logic [NUM_BTN-1:0] press_q, press_d, release_q, release_d, ien_q, ien_d;
    logic               rel_en_q, rel_en_d, irq_q, irq_d;
    logic [15:0]        deb_q, deb_d;
    logic [31:0]        rdata, data_out_q, data_out_d;
    logic [7:0]         addr;
    logic               wr_press, wr_release, wr_ien, wr_deb;
    logic               unused_bits;

    assign unused_bits = ^{address[1:0], data_in};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
            btn_debounce_ch u_ch (
                .clk       (clk),
                .reset     (reset),
                .btn_n_i   (btn_n[i]),
                .deb_i     (deb_q),
                .raw_o     (raw[i]),
                .stable_o  (stable[i]),
                .press_o   (press_p[i]),
                .release_o (release_p[i])
            );
        end
    endgenerate

    always_comb begin
        addr = {address[7:2], 2'b00};
        case (addr)
            OFF_STATUS:   rdata = 32'(stable);
            OFF_RAW:      rdata = 32'(raw);
            OFF_PRESS:    rdata = 32'(press_q);
            OFF_RELEASE:  rdata = 32'(release_q);
            OFF_IRQ_EN:   rdata = 32'(ien_q) | (32'(rel_en_q) << IRQ_REL_BIT);
            OFF_DEBOUNCE: rdata = 32'(deb_q);
            default:      rdata = 32'h0;
        endcase
        wr_press   = wen && (addr == OFF_PRESS);
        wr_release = wen && (addr == OFF_RELEASE);
        wr_ien     = wen && (addr == OFF_IRQ_EN);
        wr_deb     = wen && (addr == OFF_DEBOUNCE);
        // set pulses are OR-ed after the clear so a simultaneous event wins
        press_d    = (press_q & ~(wr_press ? data_in[NUM_BTN-1:0] : '0)) | press_p;
        release_d  = (release_q & ~(wr_release ? data_in[NUM_BTN-1:0] : '0)) | release_p;
        ien_d      = wr_ien ? data_in[NUM_BTN-1:0] : ien_q;
        rel_en_d   = wr_ien ? data_in[IRQ_REL_BIT] : rel_en_q;
        deb_d      = wr_deb ? data_in[15:0] : deb_q;
        data_out_d = ren ? rdata : data_out_q;
        irq_d      = |(press_q & ien_q) | (rel_en_q & |release_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q    <= '0;
            release_q  <= '0;
            ien_q      <= '0;
            rel_en_q   <= 1'b0;
            deb_q      <= DEB_RESET;
            data_out_q <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            press_q    <= press_d;
            release_q  <= release_d;
            ien_q      <= ien_d;
            rel_en_q   <= rel_en_d;
            deb_q      <= deb_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_button_ctrl_n.sv
// tb_button_ctrl_n: directed scenarios plus random traffic checked against a run-length debounce model.
module tb_button_ctrl_n;
    localparam int N = 10;
    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_RAW    = 8'h04;
    localparam logic [7:0] A_PRESS  = 8'h08;
    localparam logic [7:0] A_REL    = 8'h0C;
    localparam logic [7:0] A_IEN    = 8'h10;
    localparam logic [7:0] A_DEB    = 8'h14;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  btn_n = '1;
    logic [2:0]    btn_n3 = '1;
    logic          ren = 1'b0;
    logic          wen = 1'b0;
    logic [7:0]    address = 8'h0;
    logic [31:0]   data_in = 32'h0;
    logic [31:0]   data_out, data_out3;
    logic          irq, irq3;
    int            checks = 0;
    int            fails = 0;

    logic [N-1:0]  m_s1, m_s2, m_stab, m_press, m_rel, m_ien;
    logic          m_rel_en, m_irq;
    logic [15:0]   m_deb;
    logic [31:0]   m_dout;
    int            m_run [N];

    always #5 clk = ~clk;

    button_ctrl_n dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .ren(ren), .wen(wen),
        .address(address), .data_in(data_in), .data_out(data_out), .irq(irq)
    );

    button_ctrl_n #(.NUM_BTN(3)) dut3 (
        .clk(clk), .reset(reset), .btn_n(btn_n3), .ren(ren), .wen(wen),
        .address(address), .data_in(data_in), .data_out(data_out3), .irq(irq3)
    );

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_STATUS: return 32'(m_stab);
            A_RAW:    return 32'(m_s2);
            A_PRESS:  return 32'(m_press);
            A_REL:    return 32'(m_rel);
            A_IEN:    return {m_rel_en, 21'd0, m_ien};
            A_DEB:    return {16'd0, m_deb};
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_press = '0; m_rel = '0; m_ien = '0;
        m_rel_en = 1'b0; m_irq = 1'b0; m_deb = 16'hFFFF; m_dout = 32'h0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // A channel flips once the synced pin has disagreed with it for DEB consecutive edges.
    task automatic model_step();
        logic [7:0]   a;
        logic [31:0]  rd;
        logic [N-1:0] set_p, set_r, clr;
        logic         irq_n;
        int           deb_eff;
        a = {address[7:2], 2'b00};
        rd = m_read(a);
        irq_n = |(m_press & m_ien) | (m_rel_en & |m_rel);
        deb_eff = (m_deb == 16'd0) ? 1 : int'(m_deb);
        set_p = '0;
        set_r = '0;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] >= deb_eff) begin
                    m_stab[i] = ~m_stab[i];
                    m_run[i] = 0;
                    if (m_stab[i]) set_p[i] = 1'b1;
                    else set_r[i] = 1'b1;
                end
            end else m_run[i] = 0;
        end
        m_s2 = m_s1;
        m_s1 = ~btn_n;
        clr = data_in[N-1:0];
        if (wen && a == A_PRESS) m_press = m_press & ~clr;
        if (wen && a == A_REL) m_rel = m_rel & ~clr;
        if (wen && a == A_IEN) begin m_ien = clr; m_rel_en = data_in[31]; end
        if (wen && a == A_DEB) m_deb = data_in[15:0];
        m_press = m_press | set_p;
        m_rel = m_rel | set_r;
        if (ren) m_dout = rd;
        m_irq = irq_n;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wen = 1'b1; address = a; data_in = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        ren = 1'b1; address = a;
        tick();
        ren = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        model_reset();
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (data_out3 !== 32'h0 || irq3 !== 1'b0) begin fails++; $display("FAIL reset_dut3: got %h/%b want 0/0", data_out3, irq3); end
        tick();
        reset = 1'b0;
        rd(A_DEB);
        checks++; if (data_out !== 32'h0000FFFF) begin fails++; $display("FAIL reset_debounce: got %h want 0000ffff", data_out); end
        rd(A_STATUS);
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_status: got %h want 0", data_out); end
        rd(A_IEN);
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_irq_en: got %h want 0", data_out); end
    endtask

    task automatic test_press();
        wr(A_DEB, 32'd4);
        wr(A_IEN, 32'h1);
        btn_n[0] = 1'b0;
        ren = 1'b1; address = A_STATUS;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++; if (data_out !== m_dout) begin fails++; $display("FAIL press_status_edge%0d: got %h want %h", k, data_out, m_dout); end
        end
        checks++; if (data_out[0] !== 1'b0 || irq !== 1'b0) begin fails++; $display("FAIL press_early: got status0=%b irq=%b want 0/0", data_out[0], irq); end
        tick();
        ren = 1'b0;
        checks++; if (data_out[0] !== 1'b1) begin fails++; $display("FAIL press_status_6edges: got %b want 1", data_out[0]); end
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL press_irq: got %b want 1", irq); end
        rd(A_PRESS);
        checks++; if (data_out !== 32'h1 || data_out !== m_dout) begin fails++; $display("FAIL press_flag: got %h want %h", data_out, m_dout); end
        btn_n[0] = 1'b1;
        repeat (8) tick();
        wr(A_PRESS, 32'h3FF);
        wr(A_REL, 32'h3FF);
        tick();
        checks++; if (irq !== 1'b0 || irq !== m_irq) begin fails++; $display("FAIL press_irq_cleared: got %b want 0", irq); end
    endtask

    task automatic test_glitch();
        btn_n[1] = 1'b0;
        repeat (3) tick();
        btn_n[1] = 1'b1;
        repeat (8) tick();
        rd(A_STATUS);
        checks++; if (data_out[1] !== 1'b0 || data_out !== m_dout) begin fails++; $display("FAIL glitch_status: got %h want %h", data_out, m_dout); end
        rd(A_PRESS);
        checks++; if (data_out[1] !== 1'b0 || data_out !== m_dout) begin fails++; $display("FAIL glitch_press: got %h want %h", data_out, m_dout); end
    endtask

    task automatic test_w1c_race();
        btn_n[0] = 1'b0;
        repeat (5) tick();
        wen = 1'b1; address = A_PRESS; data_in = 32'h1;
        tick();
        wen = 1'b0;
        rd(A_PRESS);
        checks++; if (data_out[0] !== 1'b1 || data_out !== m_dout) begin fails++; $display("FAIL w1c_race_set_wins: got %h want %h", data_out, m_dout); end
        wr(A_PRESS, 32'h1);
        rd(A_PRESS);
        checks++; if (data_out[0] !== 1'b0) begin fails++; $display("FAIL w1c_clear: got %b want 0", data_out[0]); end
    endtask

    task automatic test_reset_mid();
        wr(A_IEN, 32'h3FF);
        btn_n[5] = 1'b0;
        repeat (8) tick();
        btn_n[4] = 1'b0;
        repeat (3) tick();
        rd(A_DEB);
        checks++; if (data_out !== 32'h4 || irq !== 1'b1) begin fails++; $display("FAIL reset_mid_before: got %h/%b want 00000004/1", data_out, irq); end
        #3 reset = 1'b1;
        #1;
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_mid_async_data: got %h want 0", data_out); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_mid_async_irq: got %b want 0", irq); end
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        wr(A_DEB, 32'd4);
        ren = 1'b1; address = A_PRESS;
        repeat (5) tick();
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_mid_no_early_press: got %h want 0", data_out); end
        tick();
        ren = 1'b0;
        checks++; if (data_out[4] !== 1'b1 || data_out !== m_dout) begin fails++; $display("FAIL reset_mid_press_after_window: got %h want %h", data_out, m_dout); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_mid_irq_en_cleared: got %b want 0", irq); end
    endtask

    task automatic test_release_irq();
        btn_n = '1;
        repeat (8) tick();
        wr(A_IEN, 32'h8000_0000);
        wr(A_PRESS, 32'h3FF);
        wr(A_REL, 32'h3FF);
        tick();
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL release_idle_irq: got %b want 0", irq); end
        btn_n[2] = 1'b0;
        repeat (8) tick();
        btn_n[2] = 1'b1;
        repeat (8) tick();
        rd(A_REL);
        checks++; if (data_out !== 32'h4 || data_out !== m_dout) begin fails++; $display("FAIL release_flag: got %h want 00000004", data_out); end
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL release_irq: got %b want 1", irq); end
        wr(A_REL, 32'h4);
        tick();
        checks++; if (irq !== 1'b0 || irq !== m_irq) begin fails++; $display("FAIL release_irq_w1c: got %b want 0", irq); end
    endtask

    task automatic test_deb_change();
        wr(A_DEB, 32'd10);
        btn_n[3] = 1'b0;
        repeat (8) tick();
        wr(A_DEB, 32'd2);
        ren = 1'b1; address = A_STATUS;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (data_out !== m_dout) begin fails++; $display("FAIL deb_change_cycle%0d: got %h want %h", k, data_out, m_dout); end
        end
        ren = 1'b0;
        checks++; if (data_out[3] !== 1'b1) begin fails++; $display("FAIL deb_change_toggle: got %b want 1", data_out[3]); end
    endtask

    task automatic test_rw_same();
        ren = 1'b1; wen = 1'b1; address = A_DEB; data_in = 32'd7;
        tick();
        ren = 1'b0; wen = 1'b0;
        checks++; if (data_out !== 32'h2 || data_out !== m_dout) begin fails++; $display("FAIL rw_same_old_value: got %h want 00000002", data_out); end
        rd(A_DEB);
        checks++; if (data_out !== 32'h7) begin fails++; $display("FAIL rw_same_new_value: got %h want 00000007", data_out); end
        wr(A_DEB, 32'd4);
    endtask

    task automatic test_unmapped();
        wr(A_STATUS, 32'hFFFF_FFFF);
        wr(A_RAW, 32'hFFFF_FFFF);
        wr(8'h18, 32'hFFFF_FFFF);
        rd(A_STATUS);
        checks++; if (data_out !== m_dout) begin fails++; $display("FAIL ro_write_ignored: got %h want %h", data_out, m_dout); end
        rd(8'h18);
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL unmapped_18: got %h want 0", data_out); end
        rd(A_DEB | 8'h3);
        checks++; if (data_out !== 32'h4) begin fails++; $display("FAIL low_addr_bits_ignored: got %h want 00000004", data_out); end
        rd(8'h20);
        checks++; if (data_out !== 32'h0) begin fails++; $display("FAIL unmapped_20: got %h want 0", data_out); end
    endtask

    task automatic test_random();
        logic [7:0] addrs [8] = '{A_STATUS, A_RAW, A_PRESS, A_REL, A_IEN, A_DEB, 8'h18, 8'h20};
        int idx, op;
        wr(A_DEB, 32'd3);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, N - 1);
                btn_n[idx] = ~btn_n[idx];
            end
            ren = 1'($urandom_range(0, 1));
            wen = 1'b0;
            address = addrs[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op == 5) begin wen = 1'b1; address = A_PRESS; data_in = $urandom; end
            if (op == 6) begin wen = 1'b1; address = A_REL; data_in = $urandom; end
            if (op == 7) begin wen = 1'b1; address = A_IEN; data_in = $urandom; end
            if (op == 8) begin wen = 1'b1; address = A_DEB; data_in = 32'($urandom_range(0, 6)); end
            tick();
            checks++; if (data_out !== m_dout) begin fails++; $display("FAIL random_data_out c%0d: got %h want %h", c, data_out, m_dout); end
            checks++; if (irq !== m_irq) begin fails++; $display("FAIL random_irq c%0d: got %b want %b", c, irq, m_irq); end
        end
        ren = 1'b0; wen = 1'b0;
        wr(A_DEB, 32'd4);
        btn_n = '1;
        repeat (10) tick();
    endtask

    task automatic test_num3();
        btn_n3 = 3'b000;
        repeat (8) tick();
        rd(A_STATUS);
        checks++; if (data_out3 !== 32'h0000_0007) begin fails++; $display("FAIL num3_status: got %h want 00000007", data_out3); end
        rd(8'h20);
        checks++; if (data_out3 !== 32'h0) begin fails++; $display("FAIL num3_unmapped: got %h want 0", data_out3); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_w1c_race();
        test_reset_mid();
        test_release_irq();
        test_deb_change();
        test_rw_same();
        test_unmapped();
        test_random();
        test_num3();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
